// File: rtl/mem_arb_pkg.sv
// Shared types and port identifiers for the data-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick: on a tie the port that did not win last time is chosen.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  always_comb begin
    gnt_id = PORT_CPU;
    case (req)
      2'b01:   gnt_id = PORT_CPU;
      2'b10:   gnt_id = PORT_LDR;
      2'b11:   gnt_id = ~last_grant;
      default: gnt_id = PORT_CPU;
    endcase
  end

  always_comb begin
    gnt = 2'b00;
    if (req != 2'b00) begin
      gnt = (gnt_id == PORT_LDR) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-port data memory between the CPU memory stage and the UART loader,
// one access at a time, with round-robin fairness and a fixed memory latency.
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              CLK,
  input  logic              reset,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,

  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [31:0]       ldr_wdata,
  output logic              ldr_ack,
  output logic              ldr_rvalid,
  output logic [31:0]       ldr_rdata,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [31:0]       mem_rdata,

  output logic              busy
);

  localparam int unsigned CntW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(MEM_LATENCY - 1);

  arb_state_t        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              ldr_rvalid_q, ldr_rvalid_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic [31:0]       ldr_rdata_q, ldr_rdata_d;

  logic [1:0] pick_gnt;
  logic       pick_id;
  logic       accept;

  rr_pick2 u_pick (
    .req        ({ldr_req, cpu_req}),
    .last_grant (last_grant_q),
    .gnt        (pick_gnt),
    .gnt_id     (pick_id)
  );

  // Acks only come out of IDLE; held low while reset is asserted so nothing is accepted then.
  assign accept  = (state_q == IDLE) && !reset && (cpu_req || ldr_req);
  assign cpu_ack = accept && pick_gnt[0];
  assign ldr_ack = accept && pick_gnt[1];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_rvalid_d = 1'b0;
    ldr_rvalid_d = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    ldr_rdata_d  = ldr_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d      = pick_id;
          last_grant_d = pick_id;
          we_d         = (pick_id == PORT_LDR) ? ldr_we    : cpu_we;
          addr_d       = (pick_id == PORT_LDR) ? ldr_addr  : cpu_addr;
          wdata_d      = (pick_id == PORT_LDR) ? ldr_wdata : cpu_wdata;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CntLoad;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Writes still signal completion but leave the owner's read data untouched.
          if (owner_q == PORT_LDR) begin
            ldr_rvalid_d = 1'b1;
            if (!we_q) ldr_rdata_d = mem_rdata;
          end else begin
            cpu_rvalid_d = 1'b1;
            if (!we_q) cpu_rdata_d = mem_rdata;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= PORT_LDR;
      owner_q      <= PORT_CPU;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rvalid_q <= 1'b0;
      ldr_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      ldr_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      ldr_rvalid_q <= ldr_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ldr_rdata_q  <= ldr_rdata_d;
    end
  end

  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_read   = (state_q == ISSUE) && !we_q;
  assign mem_write  = (state_q == ISSUE) && we_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign ldr_rvalid = ldr_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign ldr_rdata  = ldr_rdata_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter and sequencer for the data memory. It shares one data memory between the pipeline's memory-access stage (CPU port) and the UART program/data loader (LDR port). It accepts one request at a time with round-robin fairness, drives the memory's single read/write port for one cycle, and waits a fixed memory latency. It then returns a completion pulse and read data to the requester that owned the access.

## Interface
Parameters:
- `MEM_LATENCY`, default 2: cycles from the issue cycle to valid `mem_rdata`. Legal range is ≥1.
- `ADDR_W`, default 32: address width.

Ports:
- `CLK`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `cpu_req`  in  1  CPU request; held until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  ADDR_W  address.
- `cpu_wdata`  in  32  write data.
- `cpu_ack`  out  1  request accepted; combinational, one cycle.
- `cpu_rvalid`  out  1  completion pulse; registered.
- `cpu_rdata`  out  32  read data; holds its value between reads.
- `ldr_req`, `ldr_we`, `ldr_addr`, `ldr_wdata`, `ldr_ack`, `ldr_rvalid`, `ldr_rdata`: identical to the CPU port, for the loader.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  32  memory write data.
- `mem_write`  out  1  write strobe.
- `mem_read`  out  1  read strobe.
- `mem_rdata`  in  32  memory read data.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
FSM states: IDLE, ISSUE, WAIT.
- **IDLE.** If any request is present, pick one (rule below) and assert its `ack` in the same cycle.
  - At that clock edge, latch `we`, `addr`, `wdata` and the owner ID, update `last_grant`, then go to ISSUE.
  - With no request, stay in IDLE.
- **Pick rule.**
  - If only one port requests, grant it.
  - If both request, grant the port that is not `last_grant`.
- **ISSUE.** Lasts one cycle.
  - `mem_read = !we` and `mem_write = we`.
  - `mem_addr` and `mem_wdata` come from the latched values.
  - Load `cnt = MEM_LATENCY-1`, then go to WAIT.
- **WAIT.**
  - If `cnt != 0`: decrement `cnt`.
  - If `cnt == 0`: for a read, capture `mem_rdata` into the owner's `rdata`. Set the owner's `rvalid` for the next cycle and go to IDLE.
- **Completion.** `rvalid` pulses for writes as well as reads. A write leaves `rdata` unchanged.
- **Memory outputs outside ISSUE.**
  - `mem_read = mem_write = 0`.
  - `mem_addr` and `mem_wdata` hold their last latched values.
- **Request rules.**
  - A request withdrawn before `ack` has no effect.
  - A `req` still high after `ack` is treated as a new request at the next IDLE.
  - The non-selected port waits; it never receives `ack` while `busy` is high.
- **Reset.**
  - All outputs go to 0, state to IDLE, `cnt` to 0, and `last_grant` to LDR, so the CPU wins the first tie.
  - Reset during ISSUE or WAIT abandons the access: no `rvalid` is issued, and the memory strobes are low from the next cycle.

## Timing
- Request accepted in cycle T (`ack` high in T).
- ISSUE in T+1.
- WAIT from T+2 to T+1+`MEM_LATENCY`. `mem_rdata` is sampled at the end of T+1+`MEM_LATENCY`.
- `rvalid` is high in T+2+`MEM_LATENCY`. The FSM is already in IDLE in that cycle, so a new `ack` can occur in that same cycle.
- Maximum throughput is one access per `MEM_LATENCY`+2 cycles (4 cycles at the default).
- Worst-case wait for a port while the other port also requests is one full access (fairness bound).

## Structure
- Package `mem_arb_pkg`:
  - `typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t`
  - Port ID constants `PORT_CPU = 1'b0`, `PORT_LDR = 1'b1`
- One sub-module, `rr_pick2`: a combinational two-way round-robin pick.
  - Inputs: `req[1:0]`, `last_grant`.
  - Outputs: `gnt[1:0]`, `gnt_id`.
- Everything else is inline.

## Test plan
All scenarios use `MEM_LATENCY = 2`.
- **Reset.** Hold `reset` for 2 cycles → all outputs 0 and `busy` = 0.
- **CPU read.** CPU read, `addr` = 0x10 at T, memory returns 0xDEADBEEF in T+3 → `cpu_ack` at T; `mem_read` = 1 only in T+1; `cpu_rvalid` = 1 only in T+4 with `cpu_rdata` = 0xDEADBEEF; `ldr_rvalid` stays 0.
- **LDR write.** LDR write, `addr` = 0x40, `wdata` = 0x12345678 → `mem_write` = 1 in T+1 with those values; `ldr_rvalid` in T+4; `ldr_rdata` unchanged.
- **Contention.** Both ports request continuously from reset → grants alternate CPU, LDR, CPU, LDR, with `ack`s 4 cycles apart and no overlap.
- **Back-to-back.** CPU `req` held high for 3 reads → `ack`s at T, T+4 and T+8; each `rvalid` lands in the same cycle as the next `ack`.
- **Mid-op reset.** Assert `reset` in T+2 of a CPU read → no `cpu_rvalid` appears; `busy` = 0 next cycle; the next request is served normally.
